// File: rtl/card_shoe_if.sv
// card_shoe_if: request/response bus between the game FSM (master) and the card shoe (slave)
// Signals: card_req, shuffle (master -> shoe); card_valid, card_rank[3:0], card_value[5:0],
//          card_suit[1:0], cards_left[5:0], busy (shoe -> master)
interface card_shoe_if;
  logic card_req;
  logic shuffle;
  logic card_valid;
  logic [3:0] card_rank;
  logic [5:0] card_value;
  logic [1:0] card_suit;
  logic [5:0] cards_left;
  logic busy;
  modport master(output card_req, shuffle, input card_valid, card_rank, card_value, card_suit, cards_left, busy);
  modport slave(input card_req, shuffle, output card_valid, card_rank, card_value, card_suit, cards_left, busy);
endinterface

// File: rtl/card_shoe.sv
// card_shoe: one 52-card deck dealt without replacement over a req/valid handshake
// Ports: clk; reset (synchronous, active-low); bus (card_shoe_if.slave):
//   card_req/shuffle in (sampled only in IDLE), card_valid one-cycle pulse, card_rank 1..13,
//   card_value blackjack value, card_suit 0..3, cards_left 0..52, busy (not IDLE).
// Build option: define FIXED_DECK_EN to start every seek at slot 0 (deterministic deal order).
module card_shoe #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int DECK_SIZE = 52
) (
  input logic clk,
  input logic reset,
  card_shoe_if.slave bus
);
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [5:0] N = 6'(DECK_SIZE);
  typedef enum logic [1:0] {IDLE, SHUFFLE, SEEK, DEAL} state_t;
  state_t state, state_nx;
  logic [15:0] lfsr;
  logic [51:0] used;
  logic [5:0] idx, start, left, base;
  logic pend;
  logic [1:0] suit_s, suit;
  logic [3:0] rank_s, rank;
  logic [5:0] value;
`ifdef FIXED_DECK_EN
  assign start = '0;
`else
  // LFSR[5:0] spans 0..63; fold the top 12 values back into the deck
  assign start = (lfsr[5:0] >= N) ? lfsr[5:0] - N : lfsr[5:0];
`endif
  // slot -> suit/rank without a divider: suit = s/13, rank = s%13 + 1
  assign suit_s = (idx >= 6'd39) ? 2'd3 : (idx >= 6'd26) ? 2'd2 : (idx >= 6'd13) ? 2'd1 : 2'd0;
  assign base = 6'(suit_s) * 6'd13;
  assign rank_s = 4'(idx - base + 6'd1);
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: state_nx = bus.shuffle ? SHUFFLE : !bus.card_req ? IDLE : (left == '0) ? SHUFFLE : SEEK;
      SHUFFLE: state_nx = pend ? SEEK : IDLE;
      SEEK: state_nx = used[idx] ? SEEK : DEAL;
      DEAL: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      lfsr <= SEED;
      used <= '0;
      left <= N;
      idx <= '0;
      pend <= 1'b0;
      rank <= '0;
      value <= '0;
      suit <= '0;
    end else begin
      state <= state_nx;
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      // pend only matters in SHUFFLE, which is entered solely from IDLE
      if (state == IDLE) pend <= bus.card_req;
      if (state == IDLE || state == SHUFFLE) idx <= start;
      if (state == SHUFFLE) begin
        used <= '0;
        left <= N;
      end
      if (state == SEEK) begin
        if (used[idx]) idx <= (idx == N - 6'd1) ? '0 : idx + 6'd1;
        else begin
          used[idx] <= 1'b1;
          left <= left - 6'd1;
          rank <= rank_s;
          value <= (rank_s > 4'd10) ? 6'd10 : {2'b00, rank_s};
          suit <= suit_s;
        end
      end
    end
  end
  assign bus.card_valid = (state == DEAL);
  assign bus.busy = (state != IDLE);
  assign bus.card_rank = rank;
  assign bus.card_value = value;
  assign bus.card_suit = suit;
  assign bus.cards_left = left;
endmodule

// File: tb/tb_card_shoe.sv
// tb_card_shoe: directed vectors for card_shoe, expected cards checked against a deck/LFSR model
module tb_card_shoe;
  localparam logic [15:0] SEED = 16'hACE1;
  typedef struct {
    bit shf;
    bit poke;
    int gap;
    int exp_left;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [15:0] m_lfsr;
  logic [51:0] m_used;
  int m_left;
  int seen[52];
  vec_t vecs[10];
  card_shoe_if bus();
  card_shoe #(.LFSR_SEED(SEED), .DECK_SIZE(52)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [15:0] lnext(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction
  function automatic int start_of(input logic [15:0] l);
`ifdef FIXED_DECK_EN
    return 0;
`else
    int x;
    x = int'(l[5:0]);
    return (x >= 52) ? x - 52 : x;
`endif
  endfunction
  always @(posedge clk) m_lfsr <= !reset ? SEED : lnext(m_lfsr);
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic do_req(input bit shf, input bit poke, input int gap, input int exp_left);
    int s, k, n, exp_n, r;
    logic [15:0] l;
    repeat (gap) @(negedge clk);
    chk("idle_busy", int'(bus.busy), 0);
    l = m_lfsr;
    exp_n = 2;
    if (shf || m_left == 0) begin
      m_used = '0;
      m_left = 52;
      l = lnext(l);
      exp_n = 3;
    end
    s = start_of(l);
    k = 0;
    while (m_used[s]) begin
      s = (s == 51) ? 0 : s + 1;
      k++;
    end
    m_used[s] = 1'b1;
    m_left--;
    seen[s]++;
    exp_n += k;
    r = s % 13 + 1;
    bus.card_req = 1'b1;
    bus.shuffle = shf;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      bus.card_req = poke && n == 1;
      bus.shuffle = 1'b0;
    end while (!bus.card_valid && n < 60);
    chk("latency", n, exp_n);
    chk("rank", int'(bus.card_rank), r);
    chk("value", int'(bus.card_value), (r > 10) ? 10 : r);
    chk("suit", int'(bus.card_suit), s / 13);
    chk("cards_left_model", int'(bus.cards_left), m_left);
    chk("cards_left_vec", int'(bus.cards_left), exp_left);
    @(negedge clk);
    chk("valid_pulse", int'(bus.card_valid), 0);
    if (poke) begin
      n = 0;
      repeat (4) begin
        @(negedge clk);
        n += int'(bus.card_valid) + int'(bus.busy);
      end
      chk("ignored_req", n, 0);
    end
  endtask
  task automatic do_shuffle();
    @(negedge clk);
    bus.shuffle = 1'b1;
    @(negedge clk);
    bus.shuffle = 1'b0;
    chk("shuffle_busy", int'(bus.busy), 1);
    @(negedge clk);
    chk("shuffle_idle", int'(bus.busy), 0);
    chk("shuffle_left", int'(bus.cards_left), 52);
    m_used = '0;
    m_left = 52;
  endtask
  initial begin
    int n;
    vecs[0] = '{0, 0, 0, 51};
    vecs[1] = '{0, 0, 2, 50};
    vecs[2] = '{0, 1, 0, 49};
    vecs[3] = '{0, 0, 5, 48};
    vecs[4] = '{1, 0, 1, 51};
    vecs[5] = '{0, 0, 3, 50};
    vecs[6] = '{0, 1, 1, 49};
    vecs[7] = '{0, 0, 0, 48};
    vecs[8] = '{1, 1, 2, 51};
    vecs[9] = '{0, 0, 7, 50};
    bus.card_req = 1'b0;
    bus.shuffle = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(bus.card_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_left", int'(bus.cards_left), 52);
    chk("rst_rank", int'(bus.card_rank), 0);
    chk("rst_value", int'(bus.card_value), 0);
    chk("rst_suit", int'(bus.card_suit), 0);
    reset = 1'b1;
    m_used = '0;
    m_left = 52;
    foreach (vecs[i]) do_req(vecs[i].shf, vecs[i].poke, vecs[i].gap, vecs[i].exp_left);
    do_shuffle();
    foreach (seen[i]) seen[i] = 0;
    for (int i = 0; i < 52; i++) do_req(1'b0, 1'b0, int'($urandom_range(0, 3)), 51 - i);
    chk("deck_empty", int'(bus.cards_left), 0);
    n = 0;
    foreach (seen[i]) n += (seen[i] == 1) ? 1 : 0;
    chk("deck_unique", n, 52);
    do_req(1'b0, 1'b0, 1, 51);
    @(negedge clk);
    bus.card_req = 1'b1;
    @(negedge clk);
    bus.card_req = 1'b0;
    chk("seek_busy", int'(bus.busy), 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_used = '0;
    m_left = 52;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      n += int'(bus.card_valid);
    end
    chk("abort_no_valid", n, 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_left", int'(bus.cards_left), 52);
    chk("abort_rank", int'(bus.card_rank), 0);
    chk("abort_value", int'(bus.card_value), 0);
    chk("abort_suit", int'(bus.card_suit), 0);
    do_req(1'b0, 1'b0, 0, 51);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/card_shoe.md
Name: card_shoe

Overview:
- Card source that responds to card requests from the blackjack game FSM, which deals to player and dealer hands.
- Holds one 52-card deck and deals without replacement over a req/valid handshake.
- Each dealt card is reported as a rank (A..K) and a blackjack value (Ace=1, face=10) in the game's 6-bit score width.
- Reshuffles automatically when the deck is exhausted, and on an explicit shuffle request.

Parameters:
- LFSR_SEED, 16'hACE1, reset value of the free-running 16-bit LFSR. A value of 0 is replaced by 16'h0001.
- DECK_SIZE, 52, cards per deck. Fixed; any other value is unsupported.

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- reset  input  1  synchronous, active-low reset (sampled on rising clk)
- card_req  input  1  request one card; sampled only in IDLE
- shuffle  input  1  return all cards to the deck; sampled only in IDLE
- card_valid  output  1  one-cycle pulse; card_rank/card_value valid this cycle
- card_rank  output  4  1..13 (A=1, J=11, Q=12, K=13); holds last dealt card
- card_value  output  6  blackjack value: rank 1->1, 2..10->rank, 11..13->10
- card_suit  output  2  0..3, equal to slot index / 13
- cards_left  output  6  undealt cards, 0..52
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset==0 at an edge) values:
  - state=IDLE, used bitmap all 0, cards_left=52.
  - card_valid=0, card_rank=0, card_value=0, card_suit=0, busy=0.
  - LFSR=LFSR_SEED.
  - Reset mid-operation aborts any seek; no card_valid is produced.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle in every state, so user timing gives entropy.
- Slot index s (0..51): rank = s%13+1, suit = s/13.
- States: IDLE, SHUFFLE, SEEK, DEAL.
- IDLE:
  - shuffle=1 -> SHUFFLE, regardless of card_req.
  - Else card_req=1 and cards_left==0 -> SHUFFLE, with a pending request flagged.
  - Else card_req=1 -> SEEK, with idx = LFSR[5:0], minus 52 if >=52.
- SHUFFLE (1 cycle): clear bitmap, cards_left=52.
  - If a request is pending (or card_req was high together with shuffle) -> SEEK, idx loaded from LFSR as above.
  - Otherwise -> IDLE.
- SEEK (one slot per cycle):
  - used[idx]==0 -> set used[idx], cards_left decrements, latch rank/value/suit, -> DEAL.
  - Otherwise idx = (idx==51) ? 0 : idx+1; stay in SEEK.
  - Bounded at 52 cycles: cards_left>0 is guaranteed on entry.
- DEAL (1 cycle): card_valid=1, -> IDLE.
- Latency: card_req sampled at edge T gives card_valid high in the cycle after edge T+1+k, where k = occupied slots skipped.
  - Minimum 2 cycles; maximum 53 cycles (+1 if an auto-reshuffle occurs).
- card_req or shuffle while busy=1: ignored; not queued. The requester must hold or re-issue.
- card_rank/value/suit hold their values until the next deal; only card_valid pulses.
- No card is dealt twice between shuffles; exactly 52 deals are possible before an auto-reshuffle.

Optional Feature:
- Macro FIXED_DECK_EN.
- Defined: the LFSR is ignored for index selection and the seek start index is always 0. A fresh deck deals slots 0,1,2,...,51 in order, which gives a deterministic sequence for directed tests.
- Not defined: the start index comes from the LFSR as specified above. All other behaviour is identical in both builds.

Test Plan:
- FIXED_DECK_EN, reset, card_req one cycle -> card_valid exactly 2 cycles later; rank=1, value=1, suit=0, cards_left=51.
- FIXED_DECK_EN, 13 sequential requests -> ranks 1..13; values 1,2..10,10,10,10; all suit 0; cards_left=39.
- FIXED_DECK_EN, 52 requests, then a 53rd -> 53rd response takes 1 extra cycle (SHUFFLE); rank=1, suit=0, cards_left=51.
- FIXED_DECK_EN, deal 5, shuffle pulse, card_req -> cards_left returns to 52 after SHUFFLE; next card rank=1, suit=0.
- card_req pulses while busy=1, and reset asserted during SEEK -> no extra card_valid; after reset: cards_left=52, busy=0, outputs 0.
- Random build: 52 requests with varied gaps -> every (rank,suit) pair seen exactly once per scoreboard; each latency is 2..53 cycles; cards_left ends at 0.
